// File: rtl/crossbar_pkg.sv
// Shared crossbar types: transaction cell, arbiter FSM states, error pattern.
// Latency/backpressure: none (declarations only).
package crossbar_pkg;

    localparam int DATA_W     = 32;
    localparam int ADDR_MAX_W = 64;

    localparam logic [DATA_W-1:0] ERR_PATTERN = 32'hDEADBEEF;

    // Address field is sized for the widest slave; users zero-extend into it.
    typedef struct packed {
        logic                  valid;
        logic                  cmd;
        logic [ADDR_MAX_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } xact_cell_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/slave_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin finder, first valid after i_last (i_last checked last).
// Latency: 0 cycles; backpressure: none, pure function of inputs.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_valid,
    input  logic [$clog2(N)-1:0] i_last,
    output logic                 o_found,
    output logic [$clog2(N)-1:0] o_idx
);

    localparam int IW = $clog2(N);

    logic [N-1:0] w_mask;
    logic [N-1:0] w_hi;
    logic [N-1:0] w_sel;

    // Candidates above i_last take priority; otherwise wrap to the lowest valid.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N; i++) begin
            w_mask[i] = (i > int'(i_last));
        end
        w_hi    = i_valid & w_mask;
        w_sel   = (|w_hi) ? w_hi : i_valid;
        o_found = |i_valid;
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_sel[i]) begin
                o_idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/slave_port_arbiter.sv
// Round-robin share of one slave port among MASTERS one-deep cells; m_req->s_req 2 cycles, slave pulse->m_* 1 cycle.
// Full cell drops new requests (m_busy); optional watchdog under SLAVE_ARB_TIMEOUT_EN.
module slave_port_arbiter
    import crossbar_pkg::*;
#(
    parameter int MASTERS = 4,
    parameter int AW      = 30,
    parameter int TIMEOUT = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [MASTERS-1:0]             m_req,
    input  logic [MASTERS-1:0]             m_cmd,
    input  logic [MASTERS-1:0][AW-1:0]     m_addr,
    input  logic [MASTERS-1:0][DATA_W-1:0] m_wdata,
    output logic [MASTERS-1:0]             m_busy,
    output logic [MASTERS-1:0]             m_ack,
    output logic [MASTERS-1:0]             m_resp,
    output logic [MASTERS-1:0]             m_err,
    output logic [MASTERS-1:0][DATA_W-1:0] m_rdata,
    output logic                           s_req,
    output logic                           s_cmd,
    output logic [AW-1:0]                  s_addr,
    output logic [DATA_W-1:0]              s_wdata,
    input  logic                           s_ack,
    input  logic                           s_resp,
    input  logic [DATA_W-1:0]              s_rdata,
    output logic [$clog2(MASTERS)-1:0]     owner
);

    localparam int IW = $clog2(MASTERS);

    if (MASTERS < 2) begin : g_bad_masters
        $error("slave_port_arbiter: MASTERS must be >= 2");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("slave_port_arbiter: TIMEOUT must be >= 2");
    end
    if (AW < 1 || AW > ADDR_MAX_W) begin : g_bad_aw
        $error("slave_port_arbiter: AW out of range");
    end

    xact_cell_t                    r_cell [MASTERS];
    arb_state_t                    r_state;
    arb_state_t                    w_state_nxt;
    logic [IW-1:0]                 r_owner;
    logic [IW-1:0]                 r_last;
    logic [IW-1:0]                 w_pick_idx;
    logic                          w_pick_found;
    logic [MASTERS-1:0]            w_cell_vld;
    logic [MASTERS-1:0]            w_unused_addr_hi;
    logic                          w_issue;
    logic                          w_ack_pls;
    logic                          w_done;
    logic                          w_tmo;
    logic                          w_expired;
    logic                          r_s_req;
    logic                          r_s_cmd;
    logic [AW-1:0]                 r_s_addr;
    logic [DATA_W-1:0]             r_s_wdata;
    logic [MASTERS-1:0]            r_m_ack;
    logic [MASTERS-1:0]            r_m_resp;
    logic [MASTERS-1:0][DATA_W-1:0] r_m_rdata;

    always_comb begin
        w_cell_vld       = '0;
        w_unused_addr_hi = '0;
        for (int i = 0; i < MASTERS; i++) begin
            w_cell_vld[i]       = r_cell[i].valid;
            w_unused_addr_hi[i] = |(r_cell[i].addr >> AW);
        end
    end

    rr_pick #(
        .N (MASTERS)
    ) u_rr_pick (
        .i_valid (w_cell_vld),
        .i_last  (r_last),
        .o_found (w_pick_found),
        .o_idx   (w_pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A slave pulse arriving together with watchdog expiry takes precedence.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_ack_pls   = 1'b0;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_found) begin
                    w_issue     = 1'b1;
                    w_state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (s_ack) begin
                    w_ack_pls = 1'b1;
                    if (s_resp) begin
                        w_done      = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = WAIT_RESP;
                    end
                end else if (w_expired) begin
                    w_ack_pls   = 1'b1;
                    w_tmo       = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            WAIT_RESP: begin
                if (s_resp) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_expired) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < MASTERS; i++) begin
            if (!rst) begin
                r_cell[i] <= '0;
            end else if (w_issue && (w_pick_idx == IW'(i))) begin
                r_cell[i].valid <= 1'b0;
            end else if (m_req[i] && !r_cell[i].valid) begin
                r_cell[i].valid <= 1'b1;
                r_cell[i].cmd   <= m_cmd[i];
                r_cell[i].addr  <= ADDR_MAX_W'(m_addr[i]);
                r_cell[i].data  <= m_wdata[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s_req   <= 1'b0;
            r_s_cmd   <= 1'b0;
            r_s_addr  <= '0;
            r_s_wdata <= '0;
            r_owner   <= '0;
            r_last    <= IW'(MASTERS - 1);
            r_m_ack   <= '0;
            r_m_resp  <= '0;
            r_m_rdata <= '0;
        end else begin
            r_s_req  <= w_issue;
            r_m_ack  <= '0;
            r_m_resp <= '0;
            if (w_issue) begin
                r_s_cmd   <= r_cell[w_pick_idx].cmd;
                r_s_addr  <= r_cell[w_pick_idx].addr[AW-1:0];
                r_s_wdata <= r_cell[w_pick_idx].data;
                r_owner   <= w_pick_idx;
            end
            if (w_ack_pls) begin
                r_m_ack[r_owner] <= 1'b1;
            end
            if (w_done || w_tmo) begin
                r_m_resp[r_owner]  <= 1'b1;
                r_m_rdata[r_owner] <= w_done ? s_rdata : ERR_PATTERN;
                r_last             <= r_owner;
            end
        end
    end

`ifdef SLAVE_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0]      r_wdog;
    logic [MASTERS-1:0] r_m_err;

    assign w_expired = (r_wdog == CW'(TIMEOUT - 1));

    // Restarts on every state change, i.e. on entry to each wait state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wdog <= '0;
        end else if ((w_state_nxt != r_state) || (r_state == IDLE)) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_m_err <= '0;
        end else begin
            r_m_err <= '0;
            if (w_tmo) begin
                r_m_err[r_owner] <= 1'b1;
            end
        end
    end

    assign m_err = r_m_err;
`else
    assign w_expired = 1'b0;
    assign m_err     = '0;
`endif

    assign m_busy  = w_cell_vld;
    assign m_ack   = r_m_ack;
    assign m_resp  = r_m_resp;
    assign m_rdata = r_m_rdata;
    assign s_req   = r_s_req;
    assign s_cmd   = r_s_cmd;
    assign s_addr  = r_s_addr;
    assign s_wdata = r_s_wdata;
    assign owner   = r_owner;

endmodule

// File: tb/tb_slave_port_arbiter.sv
// Bench for slave_port_arbiter: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_slave_port_arbiter;

    localparam int M   = 4;
    localparam int AW  = 30;
    localparam int TMO = 8;
`ifdef SLAVE_ARB_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [M-1:0]        m_req;
    logic [M-1:0]        m_cmd;
    logic [M-1:0][AW-1:0] m_addr;
    logic [M-1:0][31:0]  m_wdata;
    logic [M-1:0]        m_busy, m_ack, m_resp, m_err;
    logic [M-1:0][31:0]  m_rdata;
    logic                s_req, s_cmd;
    logic [AW-1:0]       s_addr;
    logic [31:0]         s_wdata;
    logic                s_ack, s_resp;
    logic [31:0]         s_rdata;
    logic [1:0]          owner;

    always #5 clk = ~clk;

    slave_port_arbiter #(
        .MASTERS (M),
        .AW      (AW),
        .TIMEOUT (TMO)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_req   (m_req),
        .m_cmd   (m_cmd),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_busy  (m_busy),
        .m_ack   (m_ack),
        .m_resp  (m_resp),
        .m_err   (m_err),
        .m_rdata (m_rdata),
        .s_req   (s_req),
        .s_cmd   (s_cmd),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_ack   (s_ack),
        .s_resp  (s_resp),
        .s_rdata (s_rdata),
        .owner   (owner)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit              mv [M];
    logic            mcmd [M];
    logic [AW-1:0]   maddr [M];
    logic [31:0]     mwd [M];
    bit              fl, fl_acked, mdl_live;
    int              fl_own, fl_wait, mlast;
    logic            e_sreq, e_scmd;
    logic [AW-1:0]   e_saddr;
    logic [31:0]     e_swd;
    int              e_owner;
    logic [M-1:0]    e_mack, e_mresp, e_merr, e_busy;
    logic [31:0]     e_rdata [M];

    function automatic void finish_xact(input logic [31:0] d, input bit err);
        e_mresp[fl_own] = 1'b1;
        e_merr[fl_own]  = err;
        e_rdata[fl_own] = d;
        mlast           = fl_own;
        fl              = 1'b0;
    endfunction

    always @(posedge clk) begin : ref_model
        bit old_v [M];
        bit got;
        int c;
        old_v = mv;
        if (!rst) begin
            for (int i = 0; i < M; i++) begin
                mv[i] = 1'b0; mcmd[i] = 1'b0; maddr[i] = '0; mwd[i] = '0; e_rdata[i] = '0;
            end
            fl = 1'b0; fl_acked = 1'b0; fl_wait = 0; fl_own = 0; mlast = M - 1;
            e_sreq = 1'b0; e_scmd = 1'b0; e_saddr = '0; e_swd = '0; e_owner = 0;
            e_mack = '0; e_mresp = '0; e_merr = '0;
        end else begin
            e_sreq = 1'b0; e_mack = '0; e_mresp = '0; e_merr = '0;
            if (!fl) begin
                got = 1'b0;
                for (int k = 1; k <= M; k++) begin
                    c = (mlast + k) % M;
                    if (!got && mv[c]) begin
                        got = 1'b1; mv[c] = 1'b0;
                        e_sreq = 1'b1; e_scmd = mcmd[c]; e_saddr = maddr[c]; e_swd = mwd[c];
                        e_owner = c; fl = 1'b1; fl_own = c; fl_acked = 1'b0; fl_wait = 0;
                    end
                end
            end else begin
                fl_wait++;
                if (!fl_acked) begin
                    if (s_ack) begin
                        e_mack[fl_own] = 1'b1;
                        if (s_resp) finish_xact(s_rdata, 1'b0);
                        else begin fl_acked = 1'b1; fl_wait = 0; end
                    end else if (TMO_ON && fl_wait == TMO) begin
                        e_mack[fl_own] = 1'b1;
                        finish_xact(32'hDEADBEEF, 1'b1);
                    end
                end else begin
                    if (s_resp) finish_xact(s_rdata, 1'b0);
                    else if (TMO_ON && fl_wait == TMO) finish_xact(32'hDEADBEEF, 1'b1);
                end
            end
            for (int i = 0; i < M; i++) begin
                if (m_req[i] && !old_v[i]) begin
                    mv[i] = 1'b1; mcmd[i] = m_cmd[i]; maddr[i] = m_addr[i]; mwd[i] = m_wdata[i];
                end
            end
        end
        for (int i = 0; i < M; i++) e_busy[i] = mv[i];
        mdl_live = 1'b1;
    end

    always @(negedge clk) begin : compare
        if (mdl_live) begin
            chk("s_req", s_req, e_sreq);
            chk("s_cmd", s_cmd, e_scmd);
            chk("s_addr", s_addr, e_saddr);
            chk("s_wdata", s_wdata, e_swd);
            chk("owner", owner, e_owner);
            chk("m_busy", m_busy, e_busy);
            chk("m_ack", m_ack, e_mack);
            chk("m_resp", m_resp, e_mresp);
            chk("m_err", m_err, e_merr);
            for (int i = 0; i < M; i++) chk($sformatf("m_rdata%0d", i), m_rdata[i], e_rdata[i]);
        end
    end

    // Issue log for ordering checks.
    int issued [$];
    int sreq_cnt = 0;
    always @(negedge clk) begin
        if (s_req === 1'b1) begin
            issued.push_back(int'(owner));
            sreq_cnt++;
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wait_sreq(input string name);
        int n = 0;
        while (s_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(name, s_req, 1'b1);
    endtask

    task automatic serve(input int ad, input int rd, input logic [31:0] data);
        wait_sreq("serve_sreq");
        repeat (ad) cyc();
        s_ack = 1'b1;
        if (rd == 0) begin s_resp = 1'b1; s_rdata = data; end
        cyc();
        s_ack = 1'b0; s_resp = 1'b0;
        if (rd > 0) begin
            repeat (rd - 1) cyc();
            s_resp = 1'b1; s_rdata = data;
            cyc();
            s_resp = 1'b0;
        end
    endtask

    initial begin
        int base;
        rst = 1'b0; m_req = '0; m_cmd = '0; m_addr = '0; m_wdata = '0;
        s_ack = 1'b0; s_resp = 1'b0; s_rdata = '0;
        repeat (2) cyc();
        chk("rst_s_req", s_req, 1'b0);
        chk("rst_busy", m_busy, 4'h0);
        chk("rst_owner", owner, 2'd0);
        chk("rst_rdata", |m_rdata, 1'b0);
        rst = 1'b1;
        cyc();

        // Single read from master 2
        m_req = 4'b0100; m_cmd[2] = 1'b0; m_addr[2] = 30'h10;
        cyc();
        m_req = '0;
        chk("rd_busy_hi", m_busy[2], 1'b1);
        chk("rd_no_sreq_yet", s_req, 1'b0);
        cyc();
        chk("rd_sreq", s_req, 1'b1);
        chk("rd_addr", s_addr, 30'h10);
        chk("rd_owner", owner, 2'd2);
        chk("rd_busy_lo", m_busy[2], 1'b0);
        repeat (3) cyc();
        s_ack = 1'b1;
        cyc();
        s_ack = 1'b0;
        chk("rd_mack", m_ack, 4'b0100);
        cyc();
        s_resp = 1'b1; s_rdata = 32'hCAFE0001;
        cyc();
        s_resp = 1'b0;
        chk("rd_mresp", m_resp, 4'b0100);
        chk("rd_rdata", m_rdata[2], 32'hCAFE0001);
        chk("rd_err", m_err, 4'h0);
        repeat (2) cyc();

        // Fairness after reset
        rst = 1'b0; cyc(); rst = 1'b1;
        issued.delete();
        m_req = 4'hF;
        for (int i = 0; i < M; i++) m_addr[i] = AW'(i * 16 + 4);
        cyc();
        m_req = '0;
        for (int k = 0; k < M; k++) serve(1, 0, $urandom);
        repeat (3) cyc();
        chk("fair_cnt", issued.size(), 4);
        for (int k = 0; k < 4; k++) if (k < issued.size()) chk($sformatf("fair_order%0d", k), issued[k], k);

        // Re-request 1 and 3, combined handshake on the first
        issued.delete();
        m_req = 4'b1010;
        cyc();
        m_req = '0;
        wait_sreq("rr1_sreq");
        chk("rr1_owner", owner, 2'd1);
        cyc();
        s_ack = 1'b1; s_resp = 1'b1; s_rdata = 32'h0BAD_F00D;
        cyc();
        s_ack = 1'b0; s_resp = 1'b0;
        chk("comb_ack", m_ack, 4'b0010);
        chk("comb_resp", m_resp, 4'b0010);
        chk("comb_gap", s_req, 1'b0);
        cyc();
        chk("comb_next_sreq", s_req, 1'b1);
        chk("rr2_owner", owner, 2'd3);
        serve(0, 1, $urandom);
        repeat (2) cyc();
        chk("rr_cnt", issued.size(), 2);
        if (issued.size() == 2) begin
            chk("rr_order0", issued[0], 1);
            chk("rr_order1", issued[1], 3);
        end

        // Busy drop on master 0
        base = sreq_cnt;
        m_req = 4'b0001; m_cmd[0] = 1'b1; m_addr[0] = 30'h1234; m_wdata[0] = 32'hA5A50001;
        cyc();
        chk("drop_busy_hi", m_busy[0], 1'b1);
        m_addr[0] = 30'h3FFF; m_wdata[0] = 32'h5A5A0002;
        cyc();
        m_req = '0;
        chk("drop_sreq", s_req, 1'b1);
        chk("drop_addr", s_addr, 30'h1234);
        chk("drop_wdata", s_wdata, 32'hA5A50001);
        chk("drop_cmd", s_cmd, 1'b1);
        chk("drop_busy_lo", m_busy[0], 1'b0);
        serve(2, 1, $urandom);
        repeat (10) cyc();
        chk("drop_cnt", sreq_cnt - base, 1);

`ifdef SLAVE_ARB_TIMEOUT_EN
        m_req = 4'b0110;
        cyc();
        m_req = '0;
        wait_sreq("tmo_sreq");
        chk("tmo_owner", owner, 2'd1);
        repeat (7) cyc();
        chk("tmo_early", m_resp, 4'h0);
        cyc();
        chk("tmo_ack", m_ack, 4'b0010);
        chk("tmo_resp", m_resp, 4'b0010);
        chk("tmo_err", m_err, 4'b0010);
        chk("tmo_rdata", m_rdata[1], 32'hDEADBEEF);
        cyc();
        chk("tmo_next_sreq", s_req, 1'b1);
        chk("tmo_next_owner", owner, 2'd2);
        serve(1, 1, $urandom);
        repeat (2) cyc();
`endif

        // Reset while waiting for response
        m_req = 4'b1000;
        cyc();
        m_req = '0;
        wait_sreq("rstx_sreq");
        s_ack = 1'b1;
        cyc();
        s_ack = 1'b0;
        chk("rstx_ack", m_ack, 4'b1000);
        cyc();
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        chk("rstx_ack0", m_ack, 4'h0);
        chk("rstx_resp0", m_resp, 4'h0);
        chk("rstx_sreq0", s_req, 1'b0);
        chk("rstx_addr0", s_addr, '0);
        chk("rstx_owner0", owner, 2'd0);
        chk("rstx_rdata0", |m_rdata, 1'b0);
        s_resp = 1'b1; s_rdata = 32'h12345678;
        cyc();
        s_resp = 1'b0;
        chk("late_resp", m_resp, 4'h0);
        cyc();
        chk("late_resp2", m_resp, 4'h0);
        chk("late_rdata", m_rdata[3], 32'h0);

        // Randomized traffic, slave pulses independent of arbiter state
        for (int n = 0; n < 4000; n++) begin
            m_req = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
            m_cmd = 4'($urandom);
            for (int i = 0; i < M; i++) begin
                m_addr[i]  = AW'($urandom);
                m_wdata[i] = $urandom;
            end
            s_ack   = ($urandom_range(3) == 0);
            s_resp  = ($urandom_range(3) == 0);
            s_rdata = $urandom;
            rst     = ($urandom_range(199) != 0);
            cyc();
        end
        m_req = '0; s_ack = 1'b0; s_resp = 1'b0; rst = 1'b1;
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/slave_port_arbiter.md
# slave_port_arbiter

- Shares one slave port among `MASTERS` requesters.
- Each master has a one-deep transaction cell.
- A round-robin scheduler issues one transaction at a time to the slave and routes the slave's ack/resp back to the owning master.
- Sits between the master-side request fabric and a single slave of the interconnect.
- Uses the interconnect's pulse protocol: req → ack → resp.

## Interface
- `MASTERS`, 4: number of requesters, ≥2.
- `AW`, 30: slave-local address width.
- `TIMEOUT`, 64: watchdog limit in cycles, ≥2. Used only with `SLAVE_ARB_TIMEOUT_EN`.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `m_req`  in  [MASTERS]  one-cycle request pulse per master.
- `m_cmd`  in  [MASTERS]  0 = read, 1 = write.
- `m_addr`  in  [MASTERS][AW]  address.
- `m_wdata`  in  [MASTERS][32]  write data.
- `m_busy`  out  [MASTERS]  cell occupied; a request in this state is dropped.
- `m_ack`  out  [MASTERS]  one-cycle ack pulse.
- `m_resp`  out  [MASTERS]  one-cycle response pulse.
- `m_err`  out  [MASTERS]  error qualifier, valid with `m_resp`.
- `m_rdata`  out  [MASTERS][32]  read data, valid with `m_resp`, held otherwise.
- `s_req`  out  1  one-cycle request pulse to the slave.
- `s_cmd`  out  1  command; `s_addr`  out  AW; `s_wdata`  out  32.
- `s_ack`  in  1  slave ack pulse.
- `s_resp`  in  1  slave response pulse; `s_rdata`  in  32.
- `owner`  out  $clog2(MASTERS)  index of the master currently being served.

## Operation
**Cell capture**
- `m_req[i]` with an empty cell captures cmd/addr/wdata and sets the cell valid.
- `m_req[i]` with a full cell is ignored.
- `m_busy[i]` = cell valid, registered.

**FSM states**
- IDLE
  - Scan cells starting at `last+1`, wrapping, with `last` itself checked last. The first valid cell wins.
  - On a win: drive `s_req`/`s_cmd`/`s_addr`/`s_wdata`, set `owner`, clear the winning cell, go to WAIT_ACK.
- WAIT_ACK
  - On `s_ack`: pulse `m_ack[owner]`, go to WAIT_RESP.
  - On `s_ack` and `s_resp` together: pulse both `m_ack` and `m_resp`, go to IDLE.
- WAIT_RESP
  - On `s_resp`: pulse `m_resp[owner]`, load `m_rdata[owner]` from `s_rdata` (writes included), `m_err[owner]` = 0, set `last` = `owner`, go to IDLE.

**Boundary conditions**
- `s_ack`/`s_resp` arriving in IDLE, or `s_resp` arriving before ack in WAIT_ACK with no ack, are ignored.
- A master whose cell was cleared at issue may enqueue a new request while its first transaction is still in flight.
- Reset mid-transaction abandons it. No `m_resp` is generated, and late slave pulses are then ignored in IDLE.

**Reset values**
- All `m_*` outputs = 0, `s_*` outputs = 0.
- Cells empty, state IDLE, `owner` = 0, `last` = MASTERS-1, so master 0 wins first.

## Timing
- `m_req` in cycle 0 → cell valid and `m_busy` high in cycle 1 → `s_req` high in cycle 2, `m_busy` low in cycle 2.
- `s_ack` in cycle n → `m_ack` in cycle n+1.
- `s_resp` in cycle n → `m_resp`/`m_rdata` in cycle n+1.
- The FSM is in IDLE in cycle n+1 and may issue the next `s_req` in cycle n+2.
- All outputs are registered. `s_req`, `m_ack`, `m_resp`, `m_err` are single-cycle pulses.

## Configuration
- `SLAVE_ARB_TIMEOUT_EN` defined:
  - A watchdog counter clears on entry to WAIT_ACK and on entry to WAIT_RESP.
  - After `TIMEOUT` cycles without the awaited pulse:
    - pulse `m_resp[owner]` and `m_err[owner]`;
    - also pulse `m_ack[owner]` if the timeout occurred in WAIT_ACK;
    - set `m_rdata[owner]` = 32'hDEADBEEF;
    - set `last` = `owner`, go to IDLE.
  - An awaited pulse in the same cycle as expiry wins; no error is raised.
- `SLAVE_ARB_TIMEOUT_EN` undefined: the FSM waits indefinitely, `m_err` is constant 0, and no counter is instantiated.

## Structure
- Shared package `crossbar_pkg` holds:
  - `DATA_W` = 32;
  - the transaction-cell struct typedef (valid, cmd, addr, data);
  - the FSM state enum (IDLE, WAIT_ACK, WAIT_RESP);
  - the error pattern constant.
- Sub-module `rr_pick`: combinational round-robin finder with inputs valid vector and `last`, outputs found flag and index. Reusable by other schedulers.

## Test plan
- **Single read:** master 2 read to addr 0x10; slave acks 3 cycles after `s_req` and responds 2 cycles later with 0xCAFE0001. Expect:
  - `s_req` 2 cycles after `m_req`;
  - one `m_ack[2]` pulse;
  - `m_resp[2]` with `m_rdata[2]` = 0xCAFE0001, `m_err` = 0.
- **Fairness:** all 4 masters request in the same cycle after reset. Expect issue order 0, 1, 2, 3. Then masters 1 and 3 re-request; expect issue order 1 then 3, with `owner` matching each time.
- **Busy drop:** master 0 pulses `m_req` twice, 1 cycle apart, while its cell is full. Expect the second request dropped, `m_busy[0]` high, and exactly one `s_req` carrying the first addr/data.
- **Combined handshake:** slave asserts `s_ack` and `s_resp` together. Expect `m_ack` and `m_resp` in the same cycle and the next `s_req` 2 cycles later.
- **Timeout (macro on, `TIMEOUT` = 8):** slave never acks. Expect `m_ack`, `m_resp` and `m_err` pulsed 8 cycles after entering WAIT_ACK, `m_rdata` = 0xDEADBEEF, and the next master served.
- **Reset mid-WAIT_RESP:** assert `rst` low for 1 cycle, then the slave sends `s_resp`. Expect all outputs 0, no `m_resp`, and the late `s_resp` ignored.
